// File: rtl/fp_issue_collect.sv
// fp_issue_collect: issues requests to an attached fixed-latency FP unit,
// tracks them through a valid/tag pipe, and collects the results in order
// into a credit-managed result FIFO.
// Optional build macro: FP_ISSUE_BYPASS_EN lets a result skip an empty FIFO
// and appear on the output in its exit cycle.
module fp_issue_collect #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      unit_a,
  output logic [31:0]      unit_b,
  input  logic [31:0]      unit_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 32 + TAG_W;

  logic [LATENCY-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [EW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic [CW-1:0]      inflight_q;
  logic [CW-1:0]      inflight_d;
  logic [CW:0]        credits;
  logic               accept;
  logic               retire;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [EW-1:0]      exit_entry;
  logic [EW-1:0]      head;

  // A slot is reserved for every request from issue until its result is popped,
  // so a push can never find the FIFO full.
  assign credits    = (CW+1)'(DEPTH) - {1'b0, count_q} - {1'b0, inflight_q};
  assign in_ready   = (credits != '0);
  assign accept     = in_valid & in_ready;
  assign unit_a     = accept ? in_a : 32'h0;
  assign unit_b     = accept ? in_b : 32'h0;
  assign retire     = vld_q[LATENCY-1];
  assign exit_entry = {unit_q, tag_q[LATENCY-1]};
  assign fifo_empty = (count_q == '0);

`ifdef FP_ISSUE_BYPASS_EN
  logic bypass;
  assign bypass    = retire & fifo_empty;
  assign push      = retire & ~(bypass & out_ready);
  assign out_valid = ~fifo_empty | bypass;
  assign head      = fifo_empty ? exit_entry : mem_q[rd_ptr_q];
`else
  assign push      = retire;
  assign out_valid = ~fifo_empty;
  assign head      = mem_q[rd_ptr_q];
`endif

  // Only a buffered entry is popped; a bypassed result never enters the FIFO.
  assign pop     = out_valid & out_ready & ~fifo_empty;
  assign out_q   = out_valid ? head[EW-1:TAG_W] : 32'h0;
  assign out_tag = out_valid ? head[TAG_W-1:0] : '0;
  assign busy    = (inflight_q != '0) | ~fifo_empty;

  assign inflight_d = inflight_q + CW'(accept) - CW'(retire);
  assign count_d    = count_q + CW'(push) - CW'(pop);

  // In-flight valid pipe: entry on accept, exit LATENCY cycles later.
  always_ff @(posedge clk) begin
    if (!areset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Tag pipe runs alongside the valid pipe; contents only matter when valid.
  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  // Result storage; read side is gated by out_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= exit_entry;
    end
  end

  // FIFO pointers, occupancy and in-flight count.
  always_ff @(posedge clk) begin
    if (!areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fp_issue_collect.sv
// Bench for fp_issue_collect (default build): a LATENCY=1 instance driven by a
// vector table and scoreboarded fill/drain runs, plus a LATENCY=3 instance for
// mid-flight reset and pipe latency. The FP unit is modelled as max(a, b).
module tb_fp_issue_collect;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic areset;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- LATENCY=1, DEPTH=4 instance ----------------
  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_busy;
  logic [31:0] d1_in_a, d1_in_b, d1_unit_a, d1_unit_b, d1_unit_q, d1_out_q;
  logic [3:0]  d1_in_tag, d1_out_tag;
  logic [63:0] p1_q;

  fp_issue_collect #(.LATENCY(1), .DEPTH(4), .TAG_W(4)) dut1 (
    .clk(clk), .areset(areset),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_a(d1_in_a), .in_b(d1_in_b), .in_tag(d1_in_tag),
    .unit_a(d1_unit_a), .unit_b(d1_unit_b), .unit_q(d1_unit_q),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out_q(d1_out_q), .out_tag(d1_out_tag), .busy(d1_busy));

  always @(posedge clk) p1_q <= {d1_unit_a, d1_unit_b};
  assign d1_unit_q = fmax(p1_q[63:32], p1_q[31:0]);

  // ---------------- LATENCY=3, DEPTH=4 instance ----------------
  logic        d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_busy;
  logic [31:0] d3_in_a, d3_in_b, d3_unit_a, d3_unit_b, d3_unit_q, d3_out_q;
  logic [3:0]  d3_in_tag, d3_out_tag;
  logic [63:0] p3_q [3];

  fp_issue_collect #(.LATENCY(3), .DEPTH(4), .TAG_W(4)) dut3 (
    .clk(clk), .areset(areset),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_a(d3_in_a), .in_b(d3_in_b), .in_tag(d3_in_tag),
    .unit_a(d3_unit_a), .unit_b(d3_unit_b), .unit_q(d3_unit_q),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_q(d3_out_q), .out_tag(d3_out_tag), .busy(d3_busy));

  always @(posedge clk) begin
    p3_q[0] <= {d3_unit_a, d3_unit_b};
    p3_q[1] <= p3_q[0];
    p3_q[2] <= p3_q[1];
  end
  assign d3_unit_q = fmax(p3_q[2][63:32], p3_q[2][31:0]);

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b0;
    d1_in_valid = 1'b0; d1_out_ready = 1'b0; d1_in_a = '0; d1_in_b = '0; d1_in_tag = '0;
    d3_in_valid = 1'b0; d3_out_ready = 1'b0; d3_in_a = '0; d3_in_b = '0; d3_in_tag = '0;
    tick();
    tick();
    areset = 1'b1;
  endtask

  // Scoreboard for dut1: samples settled outputs, then advances one cycle.
  logic [35:0] sb [$];
  int n_acc, n_pop;

  task automatic cyc1();
    logic [35:0] e;
    if (d1_out_valid && d1_out_ready) begin
      n_pop++;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_pop_unexpected: got tag %0h, expected no output", d1_out_tag);
      end else begin
        e = sb.pop_front();
        chk("sb_tag", 64'(d1_out_tag), 64'(e[3:0]));
        chk("sb_q", 64'(d1_out_q), 64'(e[35:4]));
      end
    end
    if (d1_in_valid && d1_in_ready) begin
      n_acc++;
      sb.push_back({fmax(d1_in_a, d1_in_b), d1_in_tag});
    end
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        iv;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_q;
    logic [3:0]  e_tag;
    logic        e_busy;
    logic [31:0] e_ua;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] tg, input logic ordy, input logic eir,
                              input logic eov, input logic [31:0] eq, input logic [3:0] etg,
                              input logic eb, input logic [31:0] eua);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.tag = tg; v.ordy = ordy;
    v.e_irdy = eir; v.e_ov = eov; v.e_q = eq; v.e_tag = etg; v.e_busy = eb; v.e_ua = eua;
    return v;
  endfunction

  vec_t vt [12];

  initial begin
    vt[0]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 0, 32'h0,        4'd0, 0, 32'h0);
    vt[1]  = mk(1, 32'h3F800000, 32'h40000000, 4'd3, 1, 1, 0, 32'h0,        4'd0, 0, 32'h3F800000);
    vt[2]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 0, 32'h0,        4'd0, 1, 32'h0);
    vt[3]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 1, 32'h40000000, 4'd3, 1, 32'h0);
    vt[4]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 0, 32'h0,        4'd0, 0, 32'h0);
    vt[5]  = mk(1, 32'h1,        32'h5,        4'd7, 0, 1, 0, 32'h0,        4'd0, 0, 32'h1);
    vt[6]  = mk(1, 32'h9,        32'h2,        4'd8, 0, 1, 0, 32'h0,        4'd0, 1, 32'h9);
    vt[7]  = mk(0, 32'h0,        32'h0,        4'd0, 0, 1, 1, 32'h5,        4'd7, 1, 32'h0);
    vt[8]  = mk(0, 32'h0,        32'h0,        4'd0, 0, 1, 1, 32'h5,        4'd7, 1, 32'h0);
    vt[9]  = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 1, 32'h5,        4'd7, 1, 32'h0);
    vt[10] = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 1, 32'h9,        4'd8, 1, 32'h0);
    vt[11] = mk(0, 32'h0,        32'h0,        4'd0, 1, 1, 0, 32'h0,        4'd0, 0, 32'h0);

    // Table: single-request latency, buffering, hold-while-stalled, in-order pop.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      d1_in_valid = vt[i].iv; d1_in_a = vt[i].a; d1_in_b = vt[i].b;
      d1_in_tag = vt[i].tag; d1_out_ready = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(d1_in_ready), 64'(vt[i].e_irdy));
      chk($sformatf("v%0d_out_valid", i), 64'(d1_out_valid), 64'(vt[i].e_ov));
      chk($sformatf("v%0d_out_q", i), 64'(d1_out_q), 64'(vt[i].e_q));
      chk($sformatf("v%0d_out_tag", i), 64'(d1_out_tag), 64'(vt[i].e_tag));
      chk($sformatf("v%0d_busy", i), 64'(d1_busy), 64'(vt[i].e_busy));
      chk($sformatf("v%0d_unit_a", i), 64'(d1_unit_a), 64'(vt[i].e_ua));
      chk($sformatf("v%0d_unit_b", i), 64'(d1_unit_b), 64'(vt[i].e_ua != 0 ? vt[i].b : 32'h0));
      tick();
    end

    // Fill with output stalled: exactly DEPTH accepts, then drain in order.
    do_reset();
    sb.delete(); n_acc = 0; n_pop = 0;
    d1_out_ready = 1'b0; d1_in_valid = 1'b1; d1_in_b = '0;
    for (int k = 0; k < 10; k++) begin
      d1_in_tag = 4'(n_acc); d1_in_a = 32'(n_acc + 16);
      #1;
      cyc1();
    end
    chk("fill_accepts", 64'(n_acc), 64'd4);
    chk("fill_in_ready", 64'(d1_in_ready), 64'd0);
    chk("fill_busy", 64'(d1_busy), 64'd1);
    d1_in_valid = 1'b0; d1_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k == 0) chk("ready_at_first_pop", 64'(d1_in_ready), 64'd0);
      if (k == 1) chk("ready_after_first_pop", 64'(d1_in_ready), 64'd1);
      chk($sformatf("drain%0d_valid", k), 64'(d1_out_valid), 64'd1);
      chk($sformatf("drain%0d_tag", k), 64'(d1_out_tag), 64'(k));
      cyc1();
    end
    #1;
    chk("drain_pops", 64'(n_pop), 64'd4);
    chk("drain_busy", 64'(d1_busy), 64'd0);
    chk("drain_out_valid", 64'(d1_out_valid), 64'd0);
    tick();

    // Full FIFO, then 20 cycles of simultaneous issue and consume.
    do_reset();
    sb.delete(); n_acc = 0; n_pop = 0;
    d1_out_ready = 1'b0; d1_in_valid = 1'b1; d1_in_b = 32'h0;
    for (int k = 0; k < 6; k++) begin
      d1_in_tag = 4'(n_acc); d1_in_a = 32'(n_acc + 100);
      #1;
      cyc1();
    end
    chk("full_accepts", 64'(n_acc), 64'd4);
    n_acc = 0; n_pop = 0;
    d1_out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      d1_in_tag = 4'(k + 4); d1_in_a = 32'(k + 104);
      #1;
      if (k == 19) chk("steady_in_ready", 64'(d1_in_ready), 64'd1);
      cyc1();
    end
    chk("steady_pops", 64'(n_pop), 64'd20);
    chk("steady_accepts", 64'(n_acc), 64'd19);
    d1_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      cyc1();
    end
    chk("steady_no_loss", 64'(sb.size()), 64'd0);
    chk("steady_total_pops", 64'(n_pop), 64'd23);

    // LATENCY=3: reset with two requests in flight discards them.
    do_reset();
    d3_out_ready = 1'b1;
    d3_in_valid = 1'b1; d3_in_a = 32'h11; d3_in_b = 32'h22; d3_in_tag = 4'd5;
    #1;
    chk("l3_acc0_ready", 64'(d3_in_ready), 64'd1);
    tick();
    d3_in_a = 32'h33; d3_in_b = 32'h44; d3_in_tag = 4'd6;
    #1;
    chk("l3_acc1_ready", 64'(d3_in_ready), 64'd1);
    tick();
    d3_in_valid = 1'b0;
    #1;
    chk("l3_busy_inflight", 64'(d3_busy), 64'd1);
    areset = 1'b0;
    tick();
    areset = 1'b1;
    #1;
    chk("l3_busy_after_reset", 64'(d3_busy), 64'd0);
    chk("l3_ready_after_reset", 64'(d3_in_ready), 64'd1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("l3_quiet%0d_valid", k), 64'(d3_out_valid), 64'd0);
      chk($sformatf("l3_quiet%0d_busy", k), 64'(d3_busy), 64'd0);
      tick();
    end

    // LATENCY=3: fresh request appears exactly LATENCY+1 cycles after accept.
    d3_in_valid = 1'b1; d3_in_a = 32'h7; d3_in_b = 32'h3; d3_in_tag = 4'd9;
    #1;
    chk("l3_lat_accept", 64'(d3_in_ready), 64'd1);
    tick();
    d3_in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("l3_lat_t%0d_valid", k), 64'(d3_out_valid), 64'(k == 4));
      if (k == 4) begin
        chk("l3_lat_q", 64'(d3_out_q), 64'h7);
        chk("l3_lat_tag", 64'(d3_out_tag), 64'd9);
      end
      tick();
    end
    #1;
    chk("l3_lat_done", 64'(d3_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
